// File: rtl/adc_spi_responder.sv
// adc_spi_responder: ADC128S022-style 8-channel serial ADC responder, oversampled on clk_clk.
// Define ADC_RESP_ERRCHK_EN to build the sticky protocol-error checker behind proto_err.
module adc_spi_responder #(
  parameter int DATA_W = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic                adc_sclk,
  input  logic                adc_cs_n,
  input  logic                adc_din,
  output logic                adc_dout,
  input  logic [8*DATA_W-1:0] sample_data,
  output logic                frame_done,
  output logic [2:0]          last_channel,
  output logic [7:0]          ctrl_word,
  output logic                proto_err
);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_nxt;
  logic [SYNC_STAGES-1:0] sclk_s, cs_s, din_s;
  logic sclk_d, cs_d;
  logic [15:0] tx_sr, ld_word;
  logic [7:0] ctrl_sr;
  logic [3:0] rise_cnt, fall_cnt;
  logic [2:0] next_ch, cur_ch, ld_ch;
  logic sclk_q, cs_q, din_q, cs_fall, rise, fall;
  logic start, act, do_rise, do_fall, frame_end;
  // Synchronizers carry no reset so a reset with cs_n held low cannot fake a cs_n fall.
  always_ff @(posedge clk_clk) begin
    sclk_s <= {sclk_s[SYNC_STAGES-2:0], adc_sclk};
    cs_s   <= {cs_s[SYNC_STAGES-2:0], adc_cs_n};
    din_s  <= {din_s[SYNC_STAGES-2:0], adc_din};
    sclk_d <= sclk_s[SYNC_STAGES-1];
    cs_d   <= cs_s[SYNC_STAGES-1];
  end
  assign sclk_q  = sclk_s[SYNC_STAGES-1];
  assign cs_q    = cs_s[SYNC_STAGES-1];
  assign din_q   = din_s[SYNC_STAGES-1];
  assign cs_fall = cs_d & ~cs_q;
  assign rise    = ~sclk_d & sclk_q;
  assign fall    = sclk_d & ~sclk_q;
  always_ff @(posedge clk_clk)
    if (!reset_reset_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = (state == IDLE) ? (cs_fall ? ACTIVE : IDLE) : (cs_q ? IDLE : ACTIVE);
    start     = (state == IDLE) && cs_fall;
    act       = (state == ACTIVE) && !cs_q;
    do_rise   = act && rise;
    do_fall   = act && fall;
    frame_end = do_fall && (fall_cnt == 4'd15);
    ld_ch     = start ? 3'd0 : next_ch;
    ld_word   = 16'(sample_data[int'(ld_ch)*DATA_W +: DATA_W]);
  end
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      tx_sr        <= '0;
      adc_dout     <= 1'b0;
      frame_done   <= 1'b0;
      last_channel <= '0;
      ctrl_word    <= '0;
      ctrl_sr      <= '0;
      next_ch      <= '0;
      cur_ch       <= '0;
      rise_cnt     <= '0;
      fall_cnt     <= '0;
    end else begin
      frame_done <= frame_end;
      if (start) begin
        tx_sr    <= ld_word;
        adc_dout <= ld_word[15];
        cur_ch   <= '0;
        rise_cnt <= '0;
        fall_cnt <= '0;
      end else if (!act) begin
        adc_dout <= 1'b0;
        rise_cnt <= '0;
        fall_cnt <= '0;
        next_ch  <= '0;
      end else begin
        if (do_rise) begin
          if (!rise_cnt[3]) ctrl_sr <= {ctrl_sr[6:0], din_q};
          if (rise_cnt == 4'd5) next_ch <= ctrl_sr[2:0];
          if (rise_cnt == 4'd7) ctrl_word <= {ctrl_sr[6:0], din_q};
          rise_cnt <= rise_cnt + 4'd1;
        end
        if (do_fall) begin
          if (frame_end) begin
            tx_sr        <= ld_word;
            adc_dout     <= ld_word[15];
            last_channel <= cur_ch;
            cur_ch       <= next_ch;
            fall_cnt     <= '0;
          end else begin
            tx_sr    <= tx_sr << 1;
            adc_dout <= tx_sr[14];
            fall_cnt <= fall_cnt + 4'd1;
          end
        end
      end
    end
  end
`ifdef ADC_RESP_ERRCHK_EN
  logic [1:0] gap;
  logic cs_rise;
  assign cs_rise = ~cs_d & cs_q;
  // gap holds cycles since the last SCLK edge, saturating at 2.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      proto_err <= 1'b0;
      gap       <= 2'd2;
    end else begin
      gap <= (rise | fall) ? 2'd1 : (gap == 2'd2 ? 2'd2 : gap + 2'd1);
      if ((state == ACTIVE && cs_rise && fall_cnt != 4'd0) || (act && (rise | fall) && gap < 2'd2))
        proto_err <= 1'b1;
    end
  end
`else
  assign proto_err = 1'b0;
`endif
endmodule

// File: tb/tb_adc_spi_responder.sv
// tb_adc_spi_responder: randomized frame-level checks of adc_spi_responder against a channel/snapshot model.
module tb_adc_spi_responder;
  localparam int H = 6;
`ifdef ADC_RESP_ERRCHK_EN
  localparam logic ABORT_ERR = 1'b1;
`else
  localparam logic ABORT_ERR = 1'b0;
`endif
  logic clk_clk = 0, reset_reset_n = 0, adc_sclk = 1, adc_cs_n = 1, adc_din = 0;
  logic adc_dout, frame_done, proto_err;
  logic [2:0] last_channel;
  logic [7:0] ctrl_word;
  logic [95:0] sample_data;
  logic [11:0] smp [8];
  int checks = 0, fails = 0, done_cnt = 0;

  adc_spi_responder dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .adc_sclk(adc_sclk), .adc_cs_n(adc_cs_n),
    .adc_din(adc_din), .adc_dout(adc_dout), .sample_data(sample_data), .frame_done(frame_done),
    .last_channel(last_channel), .ctrl_word(ctrl_word), .proto_err(proto_err)
  );

  always #5 clk_clk = ~clk_clk;
  always @(posedge clk_clk) if (frame_done === 1'b1) done_cnt++;
  always_comb for (int k = 0; k < 8; k++) sample_data[k*12 +: 12] = smp[k];

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_clk);
    #1;
  endtask

  // Word read = DOUT sampled just before each SCLK fall, MSB first.
  task automatic run_bits(input logic [7:0] b, input int nbits, input int chg_ch,
                          input logic [11:0] chg_val, output logic [15:0] w);
    w = '0;
    for (int i = 0; i < nbits; i++) begin
      adc_din = (i < 8) ? b[7-i] : 1'($urandom);
      w[15-i] = adc_dout;
      adc_sclk = 0;
      cyc(H);
      if (i == 1 && chg_ch >= 0) smp[chg_ch] = chg_val;
      adc_sclk = 1;
      cyc(H);
    end
  endtask

  task automatic cs_low();
    adc_cs_n = 0;
    cyc(H);
  endtask

  task automatic cs_high();
    adc_cs_n = 1;
    cyc(8);
  endtask

  task automatic test_reset();
    reset_reset_n = 0;
    for (int k = 0; k < 8; k++) smp[k] = 12'($urandom);
    cyc(5);
    checks++; if (adc_dout !== 1'b0) begin fails++; $display("FAIL reset_dout got %b exp 0", adc_dout); end
    checks++; if (frame_done !== 1'b0) begin fails++; $display("FAIL reset_done got %b exp 0", frame_done); end
    checks++; if (last_channel !== 3'd0) begin fails++; $display("FAIL reset_last got %0d exp 0", last_channel); end
    checks++; if (ctrl_word !== 8'h00) begin fails++; $display("FAIL reset_ctrl got %h exp 00", ctrl_word); end
    checks++; if (proto_err !== 1'b0) begin fails++; $display("FAIL reset_perr got %b exp 0", proto_err); end
    reset_reset_n = 1;
    cyc(4);
  endtask

  task automatic test_single();
    logic [15:0] w;
    int d0;
    smp[0] = 12'hABC;
    d0 = done_cnt;
    cs_low();
    run_bits(8'h00, 16, -1, 0, w);
    checks++; if (w !== 16'h0ABC) begin fails++; $display("FAIL single_dout got %h exp 0abc", w); end
    checks++; if (done_cnt - d0 !== 1) begin fails++; $display("FAIL single_done got %0d exp 1", done_cnt - d0); end
    checks++; if (last_channel !== 3'd0) begin fails++; $display("FAIL single_last got %0d exp 0", last_channel); end
    checks++; if (ctrl_word !== 8'h00) begin fails++; $display("FAIL single_ctrl got %h exp 00", ctrl_word); end
    cs_high();
  endtask

  task automatic test_back_to_back();
    logic [15:0] w, e;
    int d0;
    smp[5] = 12'h123;
    d0 = done_cnt;
    e = 16'(smp[0]);
    cs_low();
    run_bits(8'h28, 16, -1, 0, w);
    checks++; if (w !== e) begin fails++; $display("FAIL b2b_f1_dout got %h exp %h", w, e); end
    checks++; if (ctrl_word !== 8'h28) begin fails++; $display("FAIL b2b_f1_ctrl got %h exp 28", ctrl_word); end
    run_bits(8'h28, 16, 5, 12'hFFF, w);
    checks++; if (w !== 16'h0123) begin fails++; $display("FAIL b2b_f2_dout got %h exp 0123", w); end
    checks++; if (last_channel !== 3'd5) begin fails++; $display("FAIL b2b_last got %0d exp 5", last_channel); end
    checks++; if (ctrl_word !== 8'h28) begin fails++; $display("FAIL b2b_ctrl got %h exp 28", ctrl_word); end
    checks++; if (done_cnt - d0 !== 2) begin fails++; $display("FAIL b2b_done got %0d exp 2", done_cnt - d0); end
    checks++; if (proto_err !== 1'b0) begin fails++; $display("FAIL b2b_perr got %b exp 0", proto_err); end
    cs_high();
  endtask

  task automatic test_abort();
    logic [15:0] w, e;
    logic [7:0] b;
    int d0;
    d0 = done_cnt;
    cs_low();
    run_bits(8'h38, 7, -1, 0, w);
    cs_high();
    checks++; if (done_cnt !== d0) begin fails++; $display("FAIL abort_done got %0d exp 0", done_cnt - d0); end
    checks++; if (last_channel !== 3'd5) begin fails++; $display("FAIL abort_last got %0d exp 5", last_channel); end
    checks++; if (ctrl_word !== 8'h28) begin fails++; $display("FAIL abort_ctrl got %h exp 28", ctrl_word); end
    checks++; if (proto_err !== ABORT_ERR) begin fails++; $display("FAIL abort_perr got %b exp %b", proto_err, ABORT_ERR); end
    b = 8'($urandom);
    e = 16'(smp[0]);
    cs_low();
    run_bits(b, 16, -1, 0, w);
    checks++; if (w !== e) begin fails++; $display("FAIL abort_next_dout got %h exp %h", w, e); end
    checks++; if (ctrl_word !== b) begin fails++; $display("FAIL abort_next_ctrl got %h exp %h", ctrl_word, b); end
    checks++; if (done_cnt - d0 !== 1) begin fails++; $display("FAIL abort_next_done got %0d exp 1", done_cnt - d0); end
    cs_high();
  endtask

  task automatic test_sweep();
    logic [15:0] w, e;
    logic [7:0] b;
    logic [2:0] exp_ch, prev_ch;
    int d0;
    for (int k = 0; k < 8; k++) smp[k] = {3'(k), 9'($urandom)};
    d0 = done_cnt;
    exp_ch = 0;
    cs_low();
    for (int j = 0; j < 9; j++) begin
      b = 8'($urandom);
      if (j < 8) b[5:3] = 3'(j);
      e = 16'(smp[exp_ch]);
      run_bits(b, 16, -1, 0, w);
      checks++; if (w !== e) begin fails++; $display("FAIL sweep_dout frame %0d got %h exp %h", j, w, e); end
      checks++; if (last_channel !== exp_ch) begin fails++; $display("FAIL sweep_last frame %0d got %0d exp %0d", j, last_channel, exp_ch); end
      prev_ch = exp_ch;
      exp_ch = b[5:3];
    end
    checks++; if (done_cnt - d0 !== 9) begin fails++; $display("FAIL sweep_done got %0d exp 9", done_cnt - d0); end
    checks++; if (ctrl_word !== b) begin fails++; $display("FAIL sweep_ctrl got %h exp %h (prev ch %0d)", ctrl_word, b, prev_ch); end
    cs_high();
  endtask

  task automatic test_reset_mid();
    logic [15:0] w, e;
    logic [7:0] b;
    cs_low();
    run_bits(8'($urandom), 5, -1, 0, w);
    reset_reset_n = 0;
    cyc(1);
    checks++; if (adc_dout !== 1'b0) begin fails++; $display("FAIL rmid_dout got %b exp 0", adc_dout); end
    checks++; if (frame_done !== 1'b0) begin fails++; $display("FAIL rmid_done got %b exp 0", frame_done); end
    checks++; if (last_channel !== 3'd0) begin fails++; $display("FAIL rmid_last got %0d exp 0", last_channel); end
    checks++; if (ctrl_word !== 8'h00) begin fails++; $display("FAIL rmid_ctrl got %h exp 00", ctrl_word); end
    checks++; if (proto_err !== 1'b0) begin fails++; $display("FAIL rmid_perr got %b exp 0", proto_err); end
    reset_reset_n = 1;
    cs_high();
    b = 8'($urandom);
    b[5:3] = 3'd6;
    e = 16'(smp[0]);
    cs_low();
    run_bits(b, 16, -1, 0, w);
    checks++; if (w !== e) begin fails++; $display("FAIL rmid_next_dout got %h exp %h", w, e); end
    checks++; if (last_channel !== 3'd0) begin fails++; $display("FAIL rmid_next_last got %0d exp 0", last_channel); end
    checks++; if (proto_err !== 1'b0) begin fails++; $display("FAIL rmid_next_perr got %b exp 0", proto_err); end
    cs_high();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_abort();
    test_sweep();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/adc_spi_responder.md
# adc_spi_responder

Synthesizable responder for the 4-wire ADC serial link driven by the Nios system's SPI ADC master; it models the ADC128S022-style 8-channel, 12-bit converter at the far end of the adc_sclk/adc_cs_n/adc_din/adc_dout wires. It oversamples the master's SCLK with the system clock, captures the 3-bit channel address from DIN and returns the selected channel's sample on DOUT. It replaces the physical ADC in loopback builds and serves as the bus-functional model for the audio acquisition path.

## Interface
- DATA_W, 12: sample width per channel; frame length is fixed at 16 bits, so DATA_W ≤ 16.
- SYNC_STAGES, 2: synchronizer depth on sclk/cs_n/din, ≥ 2.

- clk_clk  in  1  system clock; all logic on its rising edge.
- reset_reset_n  in  1  reset, synchronous and active-low.
- adc_sclk  in  1  serial clock from the master, idles high.
- adc_cs_n  in  1  frame select, active-low.
- adc_din  in  1  control bits from the master, sampled on SCLK rise.
- adc_dout  out  1  data bits to the master, updated on SCLK fall.
- sample_data  in  8*DATA_W  packed channel samples; channel n = [n*DATA_W +: DATA_W].
- frame_done  out  1  one-cycle pulse per completed 16-bit frame.
- last_channel  out  3  channel index sent in the last completed frame.
- ctrl_word  out  8  first 8 DIN bits of the last frame, MSB first.
- proto_err  out  1  sticky protocol-error flag (see Configuration).

## Operation
- sclk, cs_n and din each pass through SYNC_STAGES flops. Edges are detected on the synchronized sclk; din is taken from the same synchronizer stage as sclk.
- States:
  - IDLE: entered from reset and on cs_n high. adc_dout=0, counters cleared, next_ch=0.
  - ACTIVE: entered on synchronized cs_n falling. At entry, tx_sr loads {(16-DATA_W) zeros, sample[0]}, cur_ch=0, rise_cnt=fall_cnt=0.
- Rising SCLK in ACTIVE: din shifts into ctrl_sr while rise_cnt<8. On rise_cnt==5 (the 6th rise), next_ch <= {bits of rises 3,4,5}, with rise 3 as the MSB. rise_cnt wraps 15→0. On the 8th rise, ctrl_word <= ctrl_sr.
- Falling SCLK in ACTIVE:
  - fall_cnt<15: shift tx_sr left, fall_cnt++.
  - fall_cnt==15 (frame end): tx_sr <= {zeros, sample[next_ch]}, last_channel <= cur_ch, cur_ch <= next_ch, fall_cnt <= 0, frame_done pulses for one cycle.
- adc_dout = tx_sr[15] registered. Each frame therefore presents 4 leading zeros (for DATA_W=12), then the sample MSB-first.
- A sample is snapshotted at load time. Changes to sample_data mid-frame do not affect the frame in flight.
- Continuous frames without cs_n deassertion are supported. Each frame returns the channel addressed in the previous frame.
- cs_n rising mid-frame aborts the frame: go to IDLE, no frame_done, last_channel and ctrl_word unchanged.
- A cs_n rise in the same cycle as an SCLK edge: cs_n wins and the edge is ignored.
- An SCLK edge in the same cycle as the cs_n fall is ignored.

## Timing
- Reset values: adc_dout=0, frame_done=0, last_channel=0, ctrl_word=0, proto_err=0, state IDLE.
- adc_dout updates SYNC_STAGES+1 clk_clk cycles after the physical SCLK fall.
- frame_done is asserted SYNC_STAGES+1 cycles after the 16th physical SCLK fall.
- Requirements on the master: SCLK high and low phases are each ≥ SYNC_STAGES+2 clk_clk periods, and cs_n setup to the first SCLK fall is ≥ SYNC_STAGES+2 periods.
- For SCLK slower than clk_clk/8, DOUT is stable at every SCLK rise.

## Configuration
- ADC_RESP_ERRCHK_EN defined:
  - proto_err sets when cs_n rises with fall_cnt≠0, or when an SCLK edge arrives fewer than 2 cycles after the previous opposite edge.
  - proto_err clears only on reset.
- ADC_RESP_ERRCHK_EN undefined: proto_err is tied to 0 and the check logic is absent.

## Test plan
- Reset, then set sample[0]=0xABC and send one 16-bit frame with DIN=0x00 -> DOUT reads 0x0ABC, frame_done pulses once, last_channel=0.
- Two back-to-back frames with CS low, frame 1 DIN=0x28 (addr 5), sample[5]=0x123 -> frame 2 DOUT reads 0x0123, last_channel=5, ctrl_word=0x28.
- Change sample[5] to 0xFFF after the 2nd SCLK fall of frame 2 -> frame 2 still reads 0x0123.
- Raise cs_n after 7 SCLK falls, then start a new frame -> no frame_done for the aborted frame, new frame returns sample[0], proto_err=1 only when ADC_RESP_ERRCHK_EN is defined.
- Assert reset_reset_n=0 for one cycle mid-frame -> all outputs return to reset values on the next edge, and the next cs_n fall starts a clean frame returning sample[0].
- Sweep addresses 0..7 over 9 continuous frames with distinct samples -> frame k+1 returns sample[k] and frame_done pulses 9 times.
